wb_byte_serializer: RTL and testbench
=====================================

# wb_byte_serializer

Sequential Wishbone byte splitter that sits directly upstream of the 32-to-8 data resizer. It accepts one 32-bit classic access with any `wbm_sel_i` pattern and issues one downstream access per enabled byte lane, each with a one-hot select, most significant lane first. Read bytes are gathered into a 32-bit word, and the master receives a single termination. This lets 8-bit slaves behind the resizer serve halfword, word and sparse-select accesses.

## Interface
Parameters:
- `aw`, 32, address width

Ports:
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset; asynchronous, active-high
- `wbm_adr_i`  in  aw  master address
- `wbm_dat_i`  in  32  master write data
- `wbm_sel_i`  in  4  master byte selects
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i`  in  1 each  master control
- `wbm_cti_i`  in  3  ignored; every access is treated as classic
- `wbm_bte_i`  in  2  ignored
- `wbm_dat_o`  out  32  assembled read data
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o`  out  1 each  master terminations
- `wbs_adr_o`  out  aw  equals `wbm_adr_i`
- `wbs_dat_o`  out  32  equals `wbm_dat_i`
- `wbs_sel_o`  out  4  one-hot lane select of the current beat
- `wbs_we_o`  out  1  equals `wbm_we_i`
- `wbs_cyc_o`, `wbs_stb_o`  out  1 each  downstream control
- `wbs_cti_o`  out  3  constant 3'b000
- `wbs_bte_o`  out  2  constant 2'b00
- `wbs_dat_i`  in  32  downstream read data, byte placed in the selected lane
- `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i`  in  1 each  downstream terminations

## Operation
Registered state:
- `state`: one of IDLE, ACCESS, GAP, DONE
- `pend[3:0]`: lanes still to transfer
- `rbuf[31:0]`: gathered read bytes
- `term[1:0]`: pending termination type, one of ack, err or rty

IDLE:
- On `wbm_cyc_i & wbm_stb_i`: clear `rbuf` and load `pend <= wbm_sel_i`.
- If `wbm_sel_i == 0`: go to DONE with `term` = ack, and perform no downstream access.
- Otherwise go to ACCESS.

ACCESS:
- `wbs_cyc_o = wbs_stb_o = wbm_cyc_i`.
- `wbs_sel_o` = highest set bit of `pend` (priority order 3, 2, 1, 0).
- On `wbs_err_i`: `term` = err, go to DONE. Remaining lanes are abandoned.
- Else on `wbs_rty_i`: `term` = rty, go to DONE.
- Else on `wbs_ack_i`:
  - Clear the current bit in `pend`.
  - If `we` = 0, copy the selected byte lane of `wbs_dat_i` into the same lane of `rbuf`.
  - If `pend` is now empty: `term` = ack, go to DONE. Otherwise go to GAP.
- Simultaneous terminations are resolved with priority err > rty > ack.

GAP:
- `wbs_cyc_o = wbm_cyc_i`, `wbs_stb_o = 0`.
- This one-cycle gap prevents a slave with a registered acknowledge from double-acking.
- Always returns to ACCESS.

DONE:
- Exactly one of `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` is high, as selected by `term`.
- `wbm_dat_o = rbuf`. Lanes not read hold 0.
- Always returns to IDLE. A request still present in IDLE on the next cycle is a new transfer.

Master abort:
- If `wbm_cyc_i` is low while in ACCESS or GAP, downstream `cyc` and `stb` are low in that same cycle (combinational gating).
- The next state is IDLE, `pend` is cleared, and no master termination is given.
- `wbs_*` terminations are ignored outside ACCESS.

All master terminations are driven from state and are therefore registered.

Reset (asynchronous, immediate, no clock needed):
- `state` = IDLE; `pend`, `rbuf` and `term` are cleared.
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o`, `wbs_cyc_o`, `wbs_stb_o`, `wbs_sel_o` and `wbm_dat_o` are all 0.
- Reset asserted mid-transfer abandons the transfer without any termination.

## Timing
- Request presented in cycle 0. The first downstream beat is asserted in cycle 1, never combinationally in cycle 0.
- With a slave that acks in the first cycle of `stb`, an n-lane transfer (n = 1..4) has beats in cycles 1, 3, …, 2n−1 and the master ack in cycle 2n.
- With `sel` = 0, the master ack is in cycle 1.
- Each extra wait state inserted by the slave adds one cycle per beat.
- Throughput: at most one master transfer per 2n+1 cycles, because the IDLE cycle is mandatory.

## Test plan
- **Word read.** Read with `sel` = 4'hF. Slave returns lanes 3..0 = 0x11, 0x22, 0x33, 0x44 with immediate ack. Required: downstream `sel` sequence 8, 4, 2, 1 in cycles 1, 3, 5, 7; `wbm_ack_o` in cycle 8 only; `wbm_dat_o` = 0x11223344.
- **Sparse write.** Write with `sel` = 4'b0110, data 0xAABBCCDD. Required: exactly two beats, `sel` 4 then 2; `we` = 1; `wbs_dat_o` = 0xAABBCCDD on both beats; one master ack in cycle 4.
- **Empty select.** `sel` = 0. Required: `wbs_stb_o` never high; `wbm_ack_o` in cycle 1; `wbm_dat_o` = 0.
- **Error abort.** Read with `sel` = 4'hF and `wbs_err_i` on the second beat. Required: no third or fourth beat; `wbm_err_o` high for one cycle; `wbm_ack_o` never high; `wbm_dat_o` = lane 3 byte only.
- **Master abort.** Master drops `cyc` during GAP. Required: `wbs_cyc_o` low in that same cycle; IDLE on the next cycle; no termination. A following `sel` = 4'h1 read then completes normally.
- **Reset mid-transfer.** Assert `wb_rst_i` between clock edges in ACCESS. Required: all outputs 0 immediately. After release, the next request starts from IDLE with cleared `rbuf`.

Source files
------------

// File: rtl/wb_byte_serializer.sv
// Splits one 32-bit Wishbone classic access into one-hot byte-lane beats,
// most significant lane first, and gathers read bytes into a single reply.
module wb_byte_serializer #(
    parameter int aw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [31:0]   wbs_dat_o,
    output logic [3:0]    wbs_sel_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [31:0]   wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;

    localparam logic [1:0] TERM_ACK = 2'd0;
    localparam logic [1:0] TERM_ERR = 2'd1;
    localparam logic [1:0] TERM_RTY = 2'd2;

    state_t      state;
    logic [3:0]  pend;
    logic [31:0] rbuf;
    logic [1:0]  term;
    logic [3:0]  cur_sel;
    logic [31:0] lane_mask;
    logic [3:0]  pend_next;
    logic        unused;

    // Burst hints are meaningless once the access is split into byte beats.
    assign unused = ^{wbm_cti_i, wbm_bte_i};

    always_comb begin
        cur_sel = 4'b0000;
        if (pend[3])      cur_sel = 4'b1000;
        else if (pend[2]) cur_sel = 4'b0100;
        else if (pend[1]) cur_sel = 4'b0010;
        else if (pend[0]) cur_sel = 4'b0001;
    end

    assign lane_mask = {{8{cur_sel[3]}}, {8{cur_sel[2]}}, {8{cur_sel[1]}}, {8{cur_sel[0]}}};
    assign pend_next = pend & ~cur_sel;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            pend  <= 4'b0000;
            rbuf  <= 32'h0;
            term  <= TERM_ACK;
        end else begin
            case (state)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        rbuf <= 32'h0;
                        pend <= wbm_sel_i;
                        if (wbm_sel_i == 4'b0000) begin
                            term  <= TERM_ACK;
                            state <= DONE;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!wbm_cyc_i) begin
                        pend  <= 4'b0000;
                        state <= IDLE;
                    end else if (wbs_err_i) begin
                        term  <= TERM_ERR;
                        state <= DONE;
                    end else if (wbs_rty_i) begin
                        term  <= TERM_RTY;
                        state <= DONE;
                    end else if (wbs_ack_i) begin
                        pend <= pend_next;
                        if (!wbm_we_i)
                            rbuf <= (rbuf & ~lane_mask) | (wbs_dat_i & lane_mask);
                        if (pend_next == 4'b0000) begin
                            term  <= TERM_ACK;
                            state <= DONE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    // The idle-strobe cycle keeps registered-ack slaves from acking twice.
                    if (!wbm_cyc_i) begin
                        pend  <= 4'b0000;
                        state <= IDLE;
                    end else begin
                        state <= ACCESS;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream strobes are gated by the live master cyc so an abort drops them at once.
    assign wbs_cyc_o = wbm_cyc_i && ((state == ACCESS) || (state == GAP));
    assign wbs_stb_o = wbm_cyc_i && (state == ACCESS);
    assign wbs_sel_o = (state == ACCESS) ? cur_sel : 4'b0000;
    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_we_o  = wbm_we_i;
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;

    assign wbm_ack_o = (state == DONE) && (term == TERM_ACK);
    assign wbm_err_o = (state == DONE) && (term == TERM_ERR);
    assign wbm_rty_o = (state == DONE) && (term == TERM_RTY);
    assign wbm_dat_o = rbuf;

endmodule

// File: tb/tb_wb_byte_serializer.sv
// Directed bench for wb_byte_serializer: table of single transfers with a
// configurable byte slave, plus hand-written abort and reset sequences.
module tb_wb_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_adr, m_dat, m_dat_o;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb;
    logic        m_ack, m_err, m_rty;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic        s_ack, s_err, s_rty;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave behaviour knobs
    int fault_beat = 0;
    int fault_kind = 0;
    int wt         = 0;
    int beat_idx;
    logic stb_prev;

    localparam logic [31:0] SLV_WORD = 32'h11223344;

    wb_byte_serializer #(.aw(32)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(3'b111), .wbm_bte_i(2'b01),
        .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty)
    );

    always #5 clk = ~clk;

    // Byte slave: valid byte only in the selected lane, junk elsewhere.
    logic        hit, ready, fault_now;
    logic [31:0] m_lane;
    always_comb begin
        m_lane    = {{8{s_sel[3]}}, {8{s_sel[2]}}, {8{s_sel[1]}}, {8{s_sel[0]}}};
        s_dat_i   = (SLV_WORD & m_lane) | (32'hEEEEEEEE & ~m_lane);
        hit       = s_cyc && s_stb;
        ready     = (wt == 0) ? 1'b1 : stb_prev;
        fault_now = hit && ready && (fault_beat == beat_idx + 1);
        s_err     = fault_now && (fault_kind == 1 || fault_kind == 3);
        s_rty     = fault_now && (fault_kind == 2 || fault_kind == 3);
        s_ack     = hit && ready && (!fault_now || fault_kind == 3);
    end

    always_ff @(posedge clk) begin
        if (!m_cyc) begin
            beat_idx <= 0;
            stb_prev <= 1'b0;
        end else begin
            if (hit && (s_ack || s_err || s_rty)) beat_idx <= beat_idx + 1;
            stb_prev <= hit && !(s_ack || s_err || s_rty);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        logic [31:0] adr;
        int          fbeat;
        int          fkind;
        int          wt;
        int          beats;
        logic [15:0] seq;
        logic [1:0]  term;   // 0 ack, 1 err, 2 rty
        logic [31:0] rdata;
    } vec_t;

    task automatic run_txn(input string name, input vec_t v);
        int          c, nb, stb_cycles, bad_fields, term_cyc, multi, exp_tc;
        logic [15:0] seq;
        logic [1:0]  got_term;
        logic [31:0] rdata;
        logic        bad_cycle;
        nb = 0; stb_cycles = 0; bad_fields = 0; term_cyc = -1; multi = 0;
        seq = 16'h0; got_term = 2'd3; rdata = 32'hDEADBEEF; bad_cycle = 1'b0;
        fault_beat = v.fbeat; fault_kind = v.fkind; wt = v.wt;
        @(negedge clk);
        m_adr = v.adr; m_dat = v.dat; m_sel = v.sel; m_we = v.we;
        m_cyc = 1'b1; m_stb = 1'b1;
        #1;
        chk({name, " stb_in_cycle0"}, {31'h0, s_stb}, 32'h0);
        for (c = 1; c < 60; c++) begin
            @(negedge clk);
            if (s_stb) begin
                stb_cycles++;
                if (s_we !== v.we || s_dat_o !== v.dat || s_adr !== v.adr ||
                    s_cti !== 3'b000 || s_bte !== 2'b00) bad_fields++;
                if (s_ack || s_err || s_rty) begin
                    if (c != 1 + nb * (2 + v.wt) + v.wt) bad_cycle = 1'b1;
                    seq = {seq[11:0], s_sel};
                    nb++;
                end
            end
            if (m_ack || m_err || m_rty) begin
                if ((32'(m_ack) + 32'(m_err) + 32'(m_rty)) > 1) multi = 1;
                got_term = m_err ? 2'd1 : (m_rty ? 2'd2 : 2'd0);
                term_cyc = c;
                rdata    = m_dat_o;
                break;
            end
        end
        @(posedge clk);
        #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        exp_tc = (v.beats == 0) ? 1 : (1 + (v.beats - 1) * (2 + v.wt) + v.wt + 1);
        chk({name, " beats"}, nb, v.beats);
        chk({name, " sel_seq"}, {16'h0, seq}, {16'h0, v.seq});
        chk({name, " beat_timing"}, {31'h0, bad_cycle}, 32'h0);
        chk({name, " stb_cycles"}, stb_cycles, v.beats * (1 + v.wt));
        chk({name, " beat_fields"}, bad_fields, 0);
        chk({name, " term_cycle"}, term_cyc, exp_tc);
        chk({name, " term_kind"}, {30'h0, got_term}, {30'h0, v.term});
        chk({name, " single_term"}, multi, 0);
        chk({name, " rdata"}, rdata, v.rdata);
        chk({name, " term_dropped"}, {29'h0, m_ack, m_err, m_rty}, 32'h0);
    endtask

    vec_t vecs[10];

    initial begin
        rst = 1'b1;
        m_adr = 32'h0; m_dat = 32'h0; m_sel = 4'h0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        #1;
        chk("reset_outputs", {25'h0, m_ack, m_err, m_rty, s_cyc, s_stb, s_sel == 4'h0 ? 1'b0 : 1'b1}, 32'h0);
        chk("reset_rdata", m_dat_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //          sel    we    dat           adr           fb fk wt beats seq      term  rdata
        vecs[0] = '{4'hF, 1'b0, 32'h0,        32'h100,      0, 0, 0, 4, 16'h8421, 2'd0, 32'h11223344};
        vecs[1] = '{4'h6, 1'b1, 32'hAABBCCDD, 32'h204,      0, 0, 0, 2, 16'h0042, 2'd0, 32'h00000000};
        vecs[2] = '{4'h0, 1'b0, 32'h0,        32'h300,      0, 0, 0, 0, 16'h0000, 2'd0, 32'h00000000};
        vecs[3] = '{4'hA, 1'b0, 32'h0,        32'h400,      0, 0, 0, 2, 16'h0082, 2'd0, 32'h11003300};
        vecs[4] = '{4'h1, 1'b0, 32'h0,        32'h500,      0, 0, 0, 1, 16'h0001, 2'd0, 32'h00000044};
        vecs[5] = '{4'hF, 1'b0, 32'h0,        32'h600,      2, 1, 0, 2, 16'h0084, 2'd1, 32'h11000000};
        vecs[6] = '{4'h3, 1'b0, 32'h0,        32'h700,      1, 2, 0, 1, 16'h0002, 2'd2, 32'h00000000};
        vecs[7] = '{4'hC, 1'b0, 32'h0,        32'h800,      1, 3, 0, 1, 16'h0008, 2'd1, 32'h00000000};
        vecs[8] = '{4'hF, 1'b0, 32'h0,        32'h900,      0, 0, 1, 4, 16'h8421, 2'd0, 32'h11223344};
        vecs[9] = '{4'h5, 1'b1, 32'h12345678, 32'hA00,      0, 0, 1, 2, 16'h0041, 2'd0, 32'h00000000};

        for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Master abort during GAP
        fault_beat = 0; fault_kind = 0; wt = 0;
        @(negedge clk);
        m_adr = 32'hB00; m_sel = 4'hF; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_in_gap", {30'h0, s_cyc, s_stb}, 32'h2);
        m_cyc = 1'b0; m_stb = 1'b0;
        #1;
        chk("abort_cyc_drop", {30'h0, s_cyc, s_stb}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", k), {27'h0, m_ack, m_err, m_rty, s_cyc, s_stb}, 32'h0);
        end
        run_txn("after_abort", '{4'h1, 1'b0, 32'h0, 32'hB04, 0, 0, 0, 1, 16'h0001, 2'd0, 32'h00000044});

        // Asynchronous reset in the middle of the second beat
        @(negedge clk);
        m_adr = 32'hC00; m_sel = 4'hF; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_access", {28'h0, s_sel}, 32'h4);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_ctrl", {25'h0, m_ack, m_err, m_rty, s_cyc, s_stb, |s_sel}, 32'h0);
        chk("midreset_sel", {28'h0, s_sel}, 32'h0);
        chk("midreset_rdata", m_dat_o, 32'h0);
        @(posedge clk);
        #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_txn("after_reset", '{4'h4, 1'b0, 32'h0, 32'hC04, 0, 0, 0, 1, 16'h0004, 2'd0, 32'h00220000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
